// File: rtl/spi_master_rw.sv
// SPI master with read and write frames: {R/W, address, data}, all MSB first.
// The host issues a start request and the block answers with busy, then a
// single-cycle done pulse. Chip select is held high for a minimum gap after
// every frame.
//
// Ports:
//   i_clock    system clock; all logic runs on its rising edge
//   i_reset    synchronous, active-high reset
//   i_begin    start request, accepted whenever o_busy is low
//   i_rnw      1 = read, 0 = write; latched when the request is accepted
//   i_address  address field; latched when the request is accepted
//   i_wrData   write data; latched when the request is accepted
//   o_rdData   data from the last completed read
//   o_busy     a transaction is in progress
//   o_done     one-cycle pulse when a transaction ends
//   o_sen      chip select, active low
//   o_sck      SPI clock; idles low and the slave samples on its rising edge
//   o_sdat     MOSI
//   i_sout     MISO
module spi_master_rw #(
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned IDLE_CYCLES = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_begin,
    input  logic                  i_rnw,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_wrData,
    output logic [DATA_WIDTH-1:0] o_rdData,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sen,
    output logic                  o_sck,
    output logic                  o_sdat,
    input  logic                  i_sout
);

    localparam int unsigned FRAME_BITS = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned CNT_MAX    = (CLK_DIV > IDLE_CYCLES) ? CLK_DIV : IDLE_CYCLES;
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LEAD     = 3'd1;
    localparam logic [2:0] S_SHIFT_HI = 3'd2;
    localparam logic [2:0] S_SHIFT_LO = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bits_q, bits_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  rnw_q, rnw_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  sen_q, sen_d;
    logic                  sck_q, sck_d;
    logic                  sdat_q, sdat_d;

    logic [FRAME_BITS-1:0] frame;
    logic                  cnt_zero;

    // Outgoing frame; the data field is zero on reads so MOSI stays low there
    assign frame    = {i_rnw, i_address, (i_rnw ? DATA_WIDTH'(0) : i_wrData)};
    assign cnt_zero = (cnt_q == '0);

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        rnw_d   = rnw_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sen_d   = sen_q;
        sck_d   = sck_q;
        sdat_d  = sdat_q;

        case (state_q)
            S_IDLE: begin
                if (i_begin) begin
                    // First bit goes straight onto MOSI; the remainder is queued MSB-aligned
                    sdat_d  = frame[FRAME_BITS-1];
                    shreg_d = frame << 1;
                    rnw_d   = i_rnw;
                    bits_d  = BIT_W'(FRAME_BITS);
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                    busy_d  = 1'b1;
                    sen_d   = 1'b0;
                    sck_d   = 1'b0;
                    state_d = S_LEAD;
                end
            end

            S_LEAD: begin
                if (cnt_zero) begin
                    sck_d   = 1'b1;
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                    state_d = S_SHIFT_HI;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_SHIFT_HI: begin
                // SCK fall: shift out the next bit and retire the current one
                if (cnt_zero) begin
                    sck_d   = 1'b0;
                    sdat_d  = shreg_q[FRAME_BITS-1];
                    shreg_d = shreg_q << 1;
                    bits_d  = bits_q - BIT_W'(1);
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                    state_d = S_SHIFT_LO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_SHIFT_LO: begin
                if (cnt_zero) begin
                    if (bits_q != '0) begin
                        // SCK rise; bits_q remaining means bit index bits_q-1 is on the wire
                        sck_d   = 1'b1;
                        cnt_d   = CNT_W'(CLK_DIV - 1);
                        state_d = S_SHIFT_HI;
                        if (rnw_q && (bits_q <= BIT_W'(DATA_WIDTH))) begin
                            rx_d = DATA_WIDTH'({rx_q, i_sout});
                        end
                    end else begin
                        sen_d   = 1'b1;
                        sdat_d  = 1'b0;
                        cnt_d   = CNT_W'(IDLE_CYCLES - 1);
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_GAP: begin
                if (cnt_zero) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    if (rnw_q) begin
                        rd_d = rx_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            shreg_q <= '0;
            rx_q    <= '0;
            rd_q    <= '0;
            rnw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sen_q   <= 1'b1;
            sck_q   <= 1'b0;
            sdat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            rnw_q   <= rnw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sen_q   <= sen_d;
            sck_q   <= sck_d;
            sdat_q  <= sdat_d;
        end
    end

    assign o_rdData = rd_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_sen    = sen_q;
    assign o_sck    = sck_q;
    assign o_sdat   = sdat_q;

endmodule

// File: tb/tb_spi_master_rw.sv
// Directed bench for spi_master_rw: a default-parameter instance (a) and a
// wide, undivided instance (b). A negedge monitor measures each bus and plays
// the SPI slave, driving read data on SCK falling edges.
module tb_spi_master_rw;

    localparam int B_DIV  = 1;
    localparam int B_IDLE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        beg_a  = 1'b0;
    logic        rnw_a  = 1'b0;
    logic [6:0]  addr_a = '0;
    logic [7:0]  wd_a   = '0;
    logic [7:0]  rd_a;
    logic        beg_b  = 1'b0;
    logic        rnw_b  = 1'b0;
    logic [14:0] addr_b = '0;
    logic [15:0] wd_b   = '0;
    logic [15:0] rd_b;

    logic        sck [2];
    logic        sen [2];
    logic        sdat[2];
    logic        busy[2];
    logic        done[2];
    logic        sout[2];
    logic [15:0] rdv [2];

    assign rdv[0] = 16'(rd_a);
    assign rdv[1] = rd_b;

    spi_master_rw dut_a (
        .i_clock(clk), .i_reset(rst), .i_begin(beg_a), .i_rnw(rnw_a),
        .i_address(addr_a), .i_wrData(wd_a), .o_rdData(rd_a),
        .o_busy(busy[0]), .o_done(done[0]), .o_sen(sen[0]), .o_sck(sck[0]),
        .o_sdat(sdat[0]), .i_sout(sout[0])
    );

    spi_master_rw #(
        .ADDR_WIDTH(15), .DATA_WIDTH(16), .CLK_DIV(B_DIV), .IDLE_CYCLES(B_IDLE)
    ) dut_b (
        .i_clock(clk), .i_reset(rst), .i_begin(beg_b), .i_rnw(rnw_b),
        .i_address(addr_b), .i_wrData(wd_b), .o_rdData(rd_b),
        .o_busy(busy[1]), .o_done(done[1]), .o_sen(sen[1]), .o_sck(sck[1]),
        .o_sdat(sdat[1]), .i_sout(sout[1])
    );

    // Monitor state, written only by the monitor process
    int          busy_hi[2], sen_low[2], sck_sen_hi[2], dones[2], rises[2];
    int          frm_rises[2], gap_cnt[2], gap_n[2], gap_last[2], gap_prev[2];
    logic [63:0] mosi[2];
    logic [15:0] rd_at_done[2];
    logic        psck[2] = '{1'b0, 1'b0};
    int          clr_seen = 0;

    // Written only by the stimulus process
    int          clr_tok = 0;
    logic [15:0] reply[2] = '{16'h0, 16'h0};

    int n_checks = 0;
    int n_fail   = 0;

    always @(negedge clk) begin
        int nb, dw;
        if (clr_tok != clr_seen) begin
            clr_seen = clr_tok;
            for (int k = 0; k < 2; k++) begin
                busy_hi[k] = 0; sen_low[k] = 0; sck_sen_hi[k] = 0; dones[k] = 0;
                rises[k] = 0; gap_cnt[k] = 0; gap_n[k] = 0; gap_last[k] = 0;
                gap_prev[k] = 0; mosi[k] = '0; rd_at_done[k] = '0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            nb = (k == 0) ? 16 : 32;
            dw = (k == 0) ? 8 : 16;
            if (busy[k]) busy_hi[k]++;
            if (!sen[k]) sen_low[k]++;
            if (sen[k] && sck[k]) sck_sen_hi[k]++;
            if (done[k]) begin
                dones[k]++;
                rd_at_done[k] = rdv[k];
            end
            if (sck[k] && !psck[k]) begin
                rises[k]++;
                frm_rises[k]++;
                mosi[k] = {mosi[k][62:0], sdat[k]};
            end
            // Slave: present the next read-data bit after each SCK fall in the data field
            if (!sck[k] && psck[k] && frm_rises[k] >= nb - dw && frm_rises[k] < nb)
                sout[k] = reply[k][nb - 1 - frm_rises[k]];
            if (sen[k]) begin
                frm_rises[k] = 0;
                gap_cnt[k]++;
            end else if (gap_cnt[k] != 0) begin
                gap_prev[k] = gap_last[k];
                gap_last[k] = gap_cnt[k];
                gap_n[k]++;
                gap_cnt[k]  = 0;
            end
            psck[k] = sck[k];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_a(input logic r, input logic [6:0] a, input logic [7:0] d);
        clr_tok++;
        rnw_a  = r;
        addr_a = a;
        wd_a   = d;
        beg_a  = 1'b1;
        tick();
        beg_a  = 1'b0;
    endtask

    task automatic wait_dones(input int k, input int target, input int maxc, input string tag);
        for (int i = 0; i < maxc && dones[k] < target; i++) tick();
        check_eq(tag, 64'(dones[k]), 64'(target));
    endtask

    initial begin
        int bc;
        sout[0] = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_sen",  64'(sen[0]),  64'(1));
        check_eq("rst_sck",  64'(sck[0]),  64'(0));
        check_eq("rst_sdat", 64'(sdat[0]), 64'(0));
        check_eq("rst_busy", 64'(busy[0]), 64'(0));
        check_eq("rst_done", 64'(done[0]), 64'(0));
        check_eq("rst_rd",   64'(rd_a),    64'(0));
        rst = 1'b0;
        tick();

        // Write 0x12 / 0x34
        start_a(1'b0, 7'h12, 8'h34);
        wait_dones(0, 1, 300, "t1_done_seen");
        repeat (5) tick();
        check_eq("t1_mosi",    mosi[0][15:0],      64'h1234);
        check_eq("t1_rises",   64'(rises[0]),      64'(16));
        check_eq("t1_sen_low", 64'(sen_low[0]),    64'(132));
        check_eq("t1_busy",    64'(busy_hi[0]),    64'(134));
        check_eq("t1_dones",   64'(dones[0]),      64'(1));
        check_eq("t1_rd",      64'(rd_a),          64'(0));

        // Read 0x05, slave returns 0xA5
        reply[0] = 16'h00A5;
        start_a(1'b1, 7'h05, 8'hFF);
        wait_dones(0, 1, 300, "t2_done_seen");
        repeat (5) tick();
        check_eq("t2_mosi_hdr",  mosi[0][15:8],     64'h85);
        check_eq("t2_mosi_data", mosi[0][7:0],      64'h00);
        check_eq("t2_rd_done",   rd_at_done[0],     64'hA5);
        check_eq("t2_rises",     64'(rises[0]),     64'(16));

        // Three back-to-back writes with begin held high
        clr_tok++;
        rnw_a = 1'b0; addr_a = 7'h01; wd_a = 8'h10; beg_a = 1'b1;
        tick();
        wait_dones(0, 2, 400, "t3_two_done");
        beg_a = 1'b0;
        wait_dones(0, 3, 300, "t3_three_done");
        repeat (10) tick();
        check_eq("t3_dones",     64'(dones[0]),      64'(3));
        check_eq("t3_mosi",      mosi[0][47:0],      64'h011001100110);
        check_eq("t3_rises",     64'(rises[0]),      64'(48));
        check_eq("t3_gap_n",     64'(gap_n[0]),      64'(3));
        check_eq("t3_gap1",      64'(gap_prev[0]),   64'(3));
        check_eq("t3_gap2",      64'(gap_last[0]),   64'(3));
        check_eq("t3_sck_sen_hi", 64'(sck_sen_hi[0]), 64'(0));

        // Inputs and begin disturbed mid-frame
        start_a(1'b0, 7'h2A, 8'h5C);
        repeat (20) tick();
        addr_a = 7'h7F; wd_a = 8'hFF; rnw_a = 1'b1; beg_a = 1'b1;
        tick();
        beg_a = 1'b0;
        wait_dones(0, 1, 300, "t4_done_seen");
        repeat (150) tick();
        check_eq("t4_mosi",  mosi[0][15:0],   64'h2A5C);
        check_eq("t4_rises", 64'(rises[0]),   64'(16));
        check_eq("t4_dones", 64'(dones[0]),   64'(1));
        check_eq("t4_busy",  64'(busy[0]),    64'(0));
        check_eq("t4_rd",    64'(rd_a),       64'hA5);

        // Reset on the 40th busy cycle of a read
        start_a(1'b1, 7'h05, 8'h00);
        bc = 0;
        for (int i = 0; i < 200 && bc < 40; i++) begin
            if (busy[0]) bc++;
            if (bc < 40) tick();
        end
        check_eq("t5_busy40", 64'(bc), 64'(40));
        rst = 1'b1;
        tick();
        check_eq("t5_sen",  64'(sen[0]),  64'(1));
        check_eq("t5_sck",  64'(sck[0]),  64'(0));
        check_eq("t5_busy", 64'(busy[0]), 64'(0));
        check_eq("t5_done", 64'(done[0]), 64'(0));
        check_eq("t5_rd",   64'(rd_a),    64'(0));
        rst = 1'b0;
        tick();
        start_a(1'b0, 7'h33, 8'hC3);
        wait_dones(0, 1, 300, "t5_done_seen");
        repeat (5) tick();
        check_eq("t5_mosi",   mosi[0][15:0],  64'h33C3);
        check_eq("t5_rises",  64'(rises[0]),  64'(16));
        check_eq("t5_busy_n", 64'(busy_hi[0]), 64'(134));
        check_eq("t5_dones",  64'(dones[0]),  64'(1));

        // Wide instance: read 0x1234, slave returns 0xBEEF
        clr_tok++;
        reply[1] = 16'hBEEF;
        rnw_b = 1'b1; addr_b = 15'h1234; wd_b = 16'hFFFF; beg_b = 1'b1;
        tick();
        beg_b = 1'b0;
        wait_dones(1, 1, 300, "t6_done_seen");
        repeat (5) tick();
        check_eq("t6_rd",        rd_at_done[1],      64'hBEEF);
        check_eq("t6_mosi_hdr",  mosi[1][31:16],     64'h9234);
        check_eq("t6_mosi_data", mosi[1][15:0],      64'h0);
        check_eq("t6_rises",     64'(rises[1]),      64'(32));
        check_eq("t6_sen_low",   64'(sen_low[1]),    64'(B_DIV * 65));
        check_eq("t6_busy",      64'(busy_hi[1]),    64'(B_DIV * 65 + B_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
